bp_cfg_loader: RTL
==================

Name: bp_cfg_loader

Overview:
- Boot-time config-link initiator. After `start_i`, it issues the ordered sequence of config-register writes that brings a core out of reset, then hands off to normal operation.
- Write sequence: freeze, reset pulse, IDs, cache/CCE modes, CCE microcode load, unfreeze.
- Sits between host/boot logic and a tile's config-link slave port.
- Reads microcode from an external synchronous ROM and issues one outstanding write at a time, each acknowledged by the slave.

Parameters:
- cfg_addr_width_p, 32, width of config-link address.
- cfg_data_width_p, 64, width of config-link write data and ROM word.
- ucode_words_p, 256, number of CCE microcode words to load (>=1).
- ucode_addr_width_p, 8, ROM address width; 2**ucode_addr_width_p >= ucode_words_p.
- core_id_p, 0, value written to core_id and cce_id.
- did_p, 0, value written to did.
- host_did_p, 0, value written to host_did.
- icache_mode_p, 0, value written to icache_mode.
- dcache_mode_p, 0, value written to dcache_mode.
- cce_mode_p, 1, final cce_mode value.
- num_lce_p, 2, value written to num_lce.
- skip_ucode_p, 0, when 1 the microcode-write steps are omitted.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  begin sequence; sampled only in IDLE or DONE.
- ucode_v_o  out  1  ROM read enable.
- ucode_addr_o  out  ucode_addr_width_p  ROM read address.
- ucode_data_i  in  cfg_data_width_p  ROM data, valid exactly 1 cycle after ucode_v_o.
- cfg_v_o  out  1  write request valid.
- cfg_addr_o  out  cfg_addr_width_p  write address = 0x0100_0000 + register offset.
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended.
- cfg_ready_i  in  1  slave accepts request; transfer occurs when cfg_v_o & cfg_ready_i.
- cfg_ack_i  in  1  slave write-complete pulse.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence completed.

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: all outputs 0.
  - State: state=IDLE, step=0, data register=0.
  - Any in-flight request is abandoned with no further cfg_v_o.
- Write sequence, as (offset, data):
  1. 0x0002, 1 (freeze)
  2. 0x0001, 1 (reset assert)
  3. 0x0001, 0 (reset deassert)
  4. 0x0005, core_id_p
  5. 0x0006, did_p
  6. 0x0008, host_did_p
  7. 0x0021, 0 (icache id)
  8. 0x0022, icache_mode_p
  9. 0x0042, 0 (dcache id)
  10. 0x0043, dcache_mode_p
  11. 0x0080, core_id_p (cce_id)
  12. 0x0081, 0 (cce_mode uncached)
  13. 0x0082, num_lce_p
  - Then, for i=0..ucode_words_p-1: write 0x8000+i with ROM[i].
  - Then 0x0081, cce_mode_p.
  - Then 0x0002, 0 (unfreeze).
- Total writes: 15+ucode_words_p, or 15 when skip_ucode_p=1.
- States and transitions:
  - IDLE: start_i -> SEND (or FETCH if the first step is a ucode step, which never happens).
  - FETCH (ucode steps only): ucode_v_o=1 and ucode_addr_o=i for exactly 1 cycle -> LOAD.
  - LOAD: latch ucode_data_i into data register -> SEND.
  - SEND: cfg_v_o=1. On cfg_ready_i -> WAIT_ACK. Address and data must remain stable while stalled.
  - WAIT_ACK: cfg_v_o=0. On cfg_ack_i:
    - if last step -> DONE;
    - else step++ -> FETCH for a ucode step, SEND otherwise.
  - DONE: done_o=1. start_i -> restart at step 0 (done_o drops the next cycle).
- Latency:
  - start_i to first cfg_v_o: 1 cycle.
  - Non-ucode ack to next cfg_v_o: 1 cycle.
  - Ucode ack to next cfg_v_o: 3 cycles (FETCH, LOAD, SEND).
- busy_o=1 in FETCH/LOAD/SEND/WAIT_ACK; 0 in IDLE/DONE.
- Ignored inputs:
  - cfg_ack_i outside WAIT_ACK.
  - cfg_ready_i outside SEND.
  - start_i while busy.
- Ack in the same cycle the request is accepted: not legal from the slave; ignored, and the loader still waits for a later ack.
- Counters:
  - The ucode index counts 0..ucode_words_p-1 and does not wrap.
  - The step counter is sized for 15+ucode_words_p.

Test Plan:
- Default params with ucode_words_p=4, ROM[i]=0xA0+i; ready always 1, ack 2 cycles after transfer -> exactly 19 writes in the listed order. Ucode writes go to 0x0100_8000..0x0100_8003 with data 0xA0..0xA3. Final writes are 0x0100_0081=1 then 0x0100_0002=0, then done_o=1 and busy_o=0.
- Hold cfg_ready_i=0 for 5 cycles on step 4 -> cfg_v_o held 6 cycles with addr 0x0100_0005 and data core_id_p unchanged; exactly one transfer.
- Spurious cfg_ack_i pulses during SEND and IDLE -> no step advance; total write count still 19.
- Assert reset_n_i=0 during the ucode write i=2 -> all outputs 0 immediately. After release plus start_i, the sequence restarts at the freeze write.
- skip_ucode_p=1 -> 15 writes, no ucode_v_o ever asserted, done_o=1.
- start_i held high throughout -> sequence runs once. In DONE, start_i restarts the sequence and done_o drops the next cycle.

Source files
------------

// File: rtl/bp_cfg_loader.sv
// Boot-time config-link initiator: issues the ordered write sequence that brings a core out of reset.
// Latency: start to first request 1 cycle; ack to next request 1 cycle, or 3 cycles for microcode writes.
// Backpressure: one outstanding write; request held stable until cfg_ready_i, next step only after cfg_ack_i.
module bp_cfg_loader #(
   parameter int cfg_addr_width_p   = 32,
   parameter int cfg_data_width_p   = 64,
   parameter int ucode_words_p      = 256,
   parameter int ucode_addr_width_p = 8,
   parameter int core_id_p          = 0,
   parameter int did_p              = 0,
   parameter int host_did_p         = 0,
   parameter int icache_mode_p      = 0,
   parameter int dcache_mode_p      = 0,
   parameter int cce_mode_p         = 1,
   parameter int num_lce_p          = 2,
   parameter int skip_ucode_p       = 0
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          start_i,
   output logic                          ucode_v_o,
   output logic [ucode_addr_width_p-1:0] ucode_addr_o,
   input  logic [cfg_data_width_p-1:0]   ucode_data_i,
   output logic                          cfg_v_o,
   output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
   output logic [cfg_data_width_p-1:0]   cfg_data_o,
   input  logic                          cfg_ready_i,
   input  logic                          cfg_ack_i,
   output logic                          busy_o,
   output logic                          done_o
);

   // Steps 0..12 are the fixed bring-up writes, then the microcode block
   // (unless skipped), then the final cce_mode write and the unfreeze.
   localparam int num_steps_lp   = (skip_ucode_p != 0) ? 15 : 15 + ucode_words_p;
   localparam int step_width_lp  = $clog2(15 + ucode_words_p + 1);
   localparam int ucode_first_lp = 13;
   localparam int cce_step_lp    = num_steps_lp - 2;
   localparam int last_step_lp   = num_steps_lp - 1;

   localparam logic [31:0] cfg_base_lp   = 32'h0100_0000;
   localparam logic [31:0] ucode_base_lp = 32'h0100_8000;

   // Parameter values held as unsigned 32-bit so widening zero-extends.
   localparam logic [31:0] core_id_lp    = core_id_p;
   localparam logic [31:0] did_lp        = did_p;
   localparam logic [31:0] host_did_lp   = host_did_p;
   localparam logic [31:0] icache_mode_lp = icache_mode_p;
   localparam logic [31:0] dcache_mode_lp = dcache_mode_p;
   localparam logic [31:0] cce_mode_lp   = cce_mode_p;
   localparam logic [31:0] num_lce_lp    = num_lce_p;

   typedef logic [step_width_lp-1:0]      step_t;
   typedef logic [ucode_addr_width_p-1:0] uidx_t;

   localparam uidx_t last_uidx_lp = uidx_t'(ucode_words_p - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_ACK,
      ST_DONE
   } state_e;

   state_e                       state_q, state_d;
   step_t                        step_q, step_d;
   uidx_t                        uidx_q, uidx_d;
   logic [cfg_addr_width_p-1:0]  addr_q, addr_d;
   logic [cfg_data_width_p-1:0]  data_q, data_d;

   logic                         launch;
   step_t                        launch_step;

   function automatic logic is_ucode(input step_t s);
      return (skip_ucode_p == 0) && (int'(s) >= ucode_first_lp)
             && (int'(s) < ucode_first_lp + ucode_words_p);
   endfunction

   // Register offset of a non-microcode step.
   function automatic logic [15:0] step_offset(input step_t s);
      case (int'(s))
         0:       return 16'h0002;
         1:       return 16'h0001;
         2:       return 16'h0001;
         3:       return 16'h0005;
         4:       return 16'h0006;
         5:       return 16'h0008;
         6:       return 16'h0021;
         7:       return 16'h0022;
         8:       return 16'h0042;
         9:       return 16'h0043;
         10:      return 16'h0080;
         11:      return 16'h0081;
         12:      return 16'h0082;
         default: return (int'(s) == cce_step_lp) ? 16'h0081 : 16'h0002;
      endcase
   endfunction

   // Write data of a non-microcode step.
   function automatic logic [31:0] step_value(input step_t s);
      case (int'(s))
         0:       return 32'd1;
         1:       return 32'd1;
         2:       return 32'd0;
         3:       return core_id_lp;
         4:       return did_lp;
         5:       return host_did_lp;
         6:       return 32'd0;
         7:       return icache_mode_lp;
         8:       return 32'd0;
         9:       return dcache_mode_lp;
         10:      return core_id_lp;
         11:      return 32'd0;
         12:      return num_lce_lp;
         default: return (int'(s) == cce_step_lp) ? cce_mode_lp : 32'd0;
      endcase
   endfunction

   // Next-state logic: step sequencing and request address/data capture.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      uidx_d      = uidx_q;
      addr_d      = addr_q;
      data_d      = data_q;
      launch      = 1'b0;
      launch_step = '0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               launch      = 1'b1;
               launch_step = '0;
               step_d      = '0;
               uidx_d      = '0;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            data_d  = ucode_data_i;
            addr_d  = cfg_addr_width_p'(ucode_base_lp + 32'(uidx_q));
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (cfg_ready_i) begin
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (cfg_ack_i) begin
               if (step_q == step_t'(last_step_lp)) begin
                  state_d = ST_DONE;
               end else begin
                  launch      = 1'b1;
                  launch_step = step_q + step_t'(1);
                  step_d      = step_q + step_t'(1);
                  // Microcode index saturates at the last word instead of wrapping.
                  if (is_ucode(step_q) && (uidx_q != last_uidx_lp)) begin
                     uidx_d = uidx_q + uidx_t'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Microcode steps must read the ROM first; all others go straight to SEND.
      if (launch) begin
         if (is_ucode(launch_step)) begin
            state_d = ST_FETCH;
         end else begin
            state_d = ST_SEND;
            addr_d  = cfg_addr_width_p'(cfg_base_lp + {16'h0000, step_offset(launch_step)});
            data_d  = cfg_data_width_p'(step_value(launch_step));
         end
      end
   end

   // State, step counter and request registers; reset abandons any in-flight request.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         uidx_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         uidx_q  <= uidx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign ucode_v_o    = (state_q == ST_FETCH);
   assign ucode_addr_o = (state_q == ST_FETCH) ? uidx_q : '0;
   assign cfg_v_o      = (state_q == ST_SEND);
   assign cfg_addr_o   = addr_q;
   assign cfg_data_o   = data_q;
   assign busy_o       = (state_q == ST_FETCH) || (state_q == ST_LOAD)
                         || (state_q == ST_SEND) || (state_q == ST_WAIT_ACK);
   assign done_o       = (state_q == ST_DONE);

endmodule
